// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin quad-mux arbiter.
//   ST_IDLE / ST_GRANT : FSM state encodings
//   NUM_REQ            : number of requesters sharing the datapath
//   rr_pick()          : round-robin winner search starting at a pointer
package arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam int unsigned NUM_REQ = 4;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StGrant = ST_GRANT
  } arb_state_e;

  // First set request scanning ptr, ptr+1, ... (mod 4). Returns ptr if req is zero;
  // callers only use the result when at least one request is set.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/quadmux4_1.sv
// Fixed 4-bit, 4:1 multiplexer.
//   S        : select (0 -> InA ... 3 -> InD)
//   InA..InD : 4-bit data inputs
//   Out      : selected data
module quadmux4_1 (
  input  logic [1:0] S,
  input  logic [3:0] InA,
  input  logic [3:0] InB,
  input  logic [3:0] InC,
  input  logic [3:0] InD,
  output logic [3:0] Out
);

  always_comb begin
    Out = InA;
    unique case (S)
      2'd0:    Out = InA;
      2'd1:    Out = InB;
      2'd2:    Out = InC;
      2'd3:    Out = InD;
      default: Out = InA;
    endcase
  end

endmodule

// File: rtl/rr_quadmux_arbiter.sv
// Round-robin arbiter sharing one 4:1 quad-mux datapath among four requesters.
// A winner holds the datapath for a burst (until last, MAX_BURST beats, or its
// request drops), then priority rotates to the next index and a bubble cycle follows.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req[3:0]           : per-requester request, held for the whole burst
//   last[3:0]          : per-requester final-beat marker
//   data_a..data_d     : requester 0..3 data
//   out_ready          : downstream accepts a beat this cycle
//   out_valid/out_data : beat offered downstream
//   out_sel            : mux select / granted index
//   gnt[3:0]           : one-hot, high only in the cycle a beat is accepted
//   busy               : arbiter is in the grant state
module rr_quadmux_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [3:0]       last,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_c,
  input  logic [WIDTH-1:0] data_d,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic [3:0]       gnt,
  output logic             busy
);

  localparam logic [3:0] MaxBurstW = 4'(MAX_BURST);

  arb_state_e state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;

  logic       accept;
  logic [3:0] cnt_inc;

  quadmux4_1 u_mux (
    .S   (sel_q),
    .InA (data_a),
    .InB (data_b),
    .InC (data_c),
    .InD (data_d),
    .Out (out_data)
  );

  always_comb begin
    busy      = (state_q == StGrant);
    out_sel   = sel_q;
    out_valid = busy && req[sel_q];
    accept    = out_valid && out_ready;
    gnt       = accept ? (4'b0001 << sel_q) : 4'b0000;
    cnt_inc   = cnt_q + 4'd1;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req != 4'b0000) begin
          sel_d   = rr_pick(req, ptr_q);
          cnt_d   = 4'd0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (!req[sel_q]) begin
          // Requester withdrew: release without a beat.
          ptr_d   = sel_q + 2'd1;
          state_d = StIdle;
        end else if (accept) begin
          cnt_d = cnt_inc;
          // last and the burst limit hitting together is still one release.
          if (last[sel_q] || (cnt_inc == MaxBurstW)) begin
            ptr_d   = sel_q + 2'd1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rr_quadmux_arbiter.sv
// Directed, table-driven bench for rr_quadmux_arbiter. Each table row holds the
// inputs for one clock cycle and the outputs expected before that cycle's edge.
module tb_rr_quadmux_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] last;
  logic [3:0] data_a, data_b, data_c, data_d;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_sel;
  logic [3:0] gnt;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  rr_quadmux_arbiter #(
    .WIDTH     (4),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .data_a    (data_a),
    .data_b    (data_b),
    .data_c    (data_c),
    .data_d    (data_d),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .gnt       (gnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] last;
    logic       rdy;
    logic       e_valid;
    logic [3:0] e_data;
    logic [1:0] e_sel;
    logic [3:0] e_gnt;
    logic       e_busy;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs sampled 1 time unit later.
  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] ls, input logic rd);
    @(negedge clk);
    rst_n     = r;
    req       = rq;
    last      = ls;
    out_ready = rd;
    #1;
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] ls, input logic rd,
                     input logic v, input logic [3:0] d, input logic [1:0] s,
                     input logic [3:0] g, input logic b);
    vec_t t;
    t = '{r, rq, ls, rd, v, d, s, g, b};
    vq.push_back(t);
  endtask

  int  waited;
  bit  found;

  initial begin
    rst_n     = 1'b0;
    req       = 4'h0;
    last      = 4'h0;
    out_ready = 1'b1;
    data_a    = 4'h1;
    data_b    = 4'h2;
    data_c    = 4'hA;
    data_d    = 4'h4;

    // Reset with all requests high.
    add(0, 4'hF, 4'h0, 1,  0, 4'h1, 0, 4'h0, 0);
    add(0, 4'hF, 4'h0, 1,  0, 4'h1, 0, 4'h0, 0);
    // Single 2-beat burst from requester 2.
    add(1, 4'h4, 4'h0, 1,  0, 4'h1, 0, 4'h0, 0);
    add(1, 4'h4, 4'h0, 1,  1, 4'hA, 2, 4'h4, 1);
    add(1, 4'h4, 4'h4, 1,  1, 4'hA, 2, 4'h4, 1);
    add(1, 4'h0, 4'h0, 1,  0, 4'hA, 2, 4'h0, 0);
    // Reset, then round-robin 0,1,2,3,0 with one bubble between grants.
    add(0, 4'h0, 4'h0, 1,  0, 4'h1, 0, 4'h0, 0);
    add(1, 4'hF, 4'hF, 1,  0, 4'h1, 0, 4'h0, 0);
    add(1, 4'hF, 4'hF, 1,  1, 4'h1, 0, 4'h1, 1);
    add(1, 4'hF, 4'hF, 1,  0, 4'h1, 0, 4'h0, 0);
    add(1, 4'hF, 4'hF, 1,  1, 4'h2, 1, 4'h2, 1);
    add(1, 4'hF, 4'hF, 1,  0, 4'h2, 1, 4'h0, 0);
    add(1, 4'hF, 4'hF, 1,  1, 4'hA, 2, 4'h4, 1);
    add(1, 4'hF, 4'hF, 1,  0, 4'hA, 2, 4'h0, 0);
    add(1, 4'hF, 4'hF, 1,  1, 4'h4, 3, 4'h8, 1);
    add(1, 4'hF, 4'hF, 1,  0, 4'h4, 3, 4'h0, 0);
    add(1, 4'hF, 4'hF, 1,  1, 4'h1, 0, 4'h1, 1);
    // MAX_BURST on requester 1: four beats, forced release, then requester 2 wins.
    add(1, 4'h2, 4'h0, 1,  0, 4'h1, 0, 4'h0, 0);
    for (int i = 0; i < 4; i++) add(1, 4'h2, 4'h0, 1,  1, 4'h2, 1, 4'h2, 1);
    add(1, 4'h6, 4'h0, 1,  0, 4'h2, 1, 4'h0, 0);
    // Backpressure mid-burst: count must hold, so release lands after 4 accepted beats.
    add(1, 4'h4, 4'h0, 1,  1, 4'hA, 2, 4'h4, 1);
    for (int i = 0; i < 3; i++) add(1, 4'h4, 4'h0, 0,  1, 4'hA, 2, 4'h0, 1);
    for (int i = 0; i < 3; i++) add(1, 4'h4, 4'h0, 1,  1, 4'hA, 2, 4'h4, 1);
    add(1, 4'h0, 4'h0, 1,  0, 4'hA, 2, 4'h0, 0);
    // Withdraw: requester 0 granted then drops req; ptr=1 so requester 1 wins next.
    add(1, 4'h1, 4'h0, 1,  0, 4'hA, 2, 4'h0, 0);
    add(1, 4'h0, 4'h0, 1,  0, 4'h1, 0, 4'h0, 1);
    add(1, 4'h3, 4'h0, 1,  0, 4'h1, 0, 4'h0, 0);
    add(1, 4'h3, 4'h0, 1,  1, 4'h2, 1, 4'h2, 1);
    // Mid-burst reset clears at once and returns ptr to 0.
    add(0, 4'h3, 4'h0, 1,  0, 4'h1, 0, 4'h0, 0);
    add(1, 4'h3, 4'h0, 1,  0, 4'h1, 0, 4'h0, 0);
    add(1, 4'h3, 4'h0, 1,  1, 4'h1, 0, 4'h1, 1);
    add(1, 4'h3, 4'h1, 1,  1, 4'h1, 0, 4'h1, 1);
    add(1, 4'h0, 4'h0, 1,  0, 4'h1, 0, 4'h0, 0);

    foreach (vq[i]) begin
      drive(vq[i].rst_n, vq[i].req, vq[i].last, vq[i].rdy);
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vq[i].e_valid));
      check($sformatf("v%0d out_data", i),  32'(out_data),  32'(vq[i].e_data));
      check($sformatf("v%0d out_sel", i),   32'(out_sel),   32'(vq[i].e_sel));
      check($sformatf("v%0d gnt", i),       32'(gnt),       32'(vq[i].e_gnt));
      check($sformatf("v%0d busy", i),      32'(busy),      32'(vq[i].e_busy));
    end

    // last coinciding with the 4th beat: one release, then requester 1 wins again
    // (ptr=2, scan 2,3,0,1) after exactly one bubble.
    drive(1, 4'h2, 4'h0, 1);
    check("lm idle busy", 32'(busy), 32'd0);
    for (int b = 0; b < 3; b++) begin
      drive(1, 4'h2, 4'h0, 1);
      check($sformatf("lm beat%0d gnt", b), 32'(gnt), 32'h2);
    end
    drive(1, 4'h2, 4'h2, 1);
    check("lm beat3 gnt", 32'(gnt), 32'h2);
    drive(1, 4'h2, 4'h0, 1);
    check("lm bubble busy", 32'(busy), 32'd0);
    check("lm bubble gnt", 32'(gnt), 32'h0);
    drive(1, 4'h2, 4'h2, 1);
    check("lm regrant sel", 32'(out_sel), 32'd1);
    check("lm regrant gnt", 32'(gnt), 32'h2);

    // Bounded wait for requester 3's grant.
    drive(1, 4'h8, 4'h8, 1);
    check("w idle gnt", 32'(gnt), 32'h0);
    found  = 1'b0;
    waited = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      #1;
      waited = k + 1;
      if (gnt == 4'h8) found = 1'b1;
    end
    check("w grant seen", 32'(found), 32'd1);
    check("w latency", 32'(waited), 32'd1);
    check("w data", 32'(out_data), 32'h4);

    drive(1, 4'h0, 4'h0, 1);
    check("end idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
